// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - UART transmitter: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits
module uart_transmit #(
    parameter int CLK_HZ    = 5_000_000,
    parameter int BAUD      = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] dataIn,
    input  logic       send,
    output logic       ready,
    output logic       tx,
    output logic       finished_send
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $fatal(1, "uart_transmit: CLK_HZ/BAUD must be at least 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $fatal(1, "uart_transmit: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $fatal(1, "uart_transmit: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            tx            <= 1'b1;
            ready         <= 1'b1;
            finished_send <= 1'b0;
            bit_cnt       <= '0;
            baud_cnt      <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
        end else begin
            finished_send <= 1'b0;
            if (state != S_IDLE) begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (send && ready) begin
                        shreg    <= dataIn;
                        // Parity is fixed at accept so later dataIn changes cannot leak in
                        par_bit  <= (PARITY == 2) ? ^dataIn : ~^dataIn;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        ready    <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_wrap) begin
                        tx    <= shreg[0];
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_wrap) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Raised one edge early so the registered pulse lands on the last stop cycle
                    if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE) begin
                        finished_send <= 1'b1;
                    end
                    if (baud_wrap) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            ready   <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - self-checking bench for uart_transmit against a slot-level line model
module tb_uart_transmit;

    logic       clk;
    logic [4:0] rst, snd, rdy, txs, fin;
    logic [7:0] din [5];
    int         total, bad;
    logic [11:0] obs_bits;
    int         last_fin_cycle;
    int         u_clks [5];
    int         u_par  [5];
    int         u_stop [5];

    generate
        for (genvar g = 0; g < 5; g++) begin : g_dut
            uart_transmit #(
                .CLK_HZ   (g < 3 ? 5_000_000 : (g == 3 ? 40_000 : 29_000)),
                .BAUD     (9600),
                .PARITY   (g == 1 ? 2 : ((g == 2 || g == 3) ? 1 : 0)),
                .STOP_BITS((g == 1 || g == 2 || g == 4) ? 2 : 1)
            ) dut (
                .clock        (clk),
                .reset        (rst[g]),
                .dataIn       (din[g]),
                .send         (snd[g]),
                .ready        (rdy[g]),
                .tx           (txs[g]),
                .finished_send(fin[g])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sends one byte on unit u and checks every cycle of the frame against the slot model.
    task automatic do_frame(input int u, input logic [7:0] b, input bit hold, input bit noise);
        logic [11:0] expv;
        int nslot, clks, f, c, ones, rdy_bad, fin_early;
        logic fin_last, bad_slot, bad_val;
        clks = u_clks[u];
        ones = $countones(b);
        expv = '1;
        expv[0] = 1'b0;
        for (int i = 0; i < 8; i++) expv[i+1] = b[i];
        nslot = 10 + (u_par[u] != 0 ? 1 : 0) + (u_stop[u] - 1);
        if (u_par[u] == 2) expv[9] = (ones % 2 == 1);
        if (u_par[u] == 1) expv[9] = (ones % 2 == 0);
        f = nslot * clks;
        rdy_bad = 0; fin_early = 0; fin_last = 1'b0; last_fin_cycle = -1;

        din[u] = b;
        snd[u] = 1'b1;
        total++;
        if (rdy[u] !== 1'b1) begin
            bad++; $display("FAIL u%0d ready before accept: got %b want 1", u, rdy[u]);
        end
        @(negedge clk);
        if (!hold) snd[u] = 1'b0;
        for (int s = 0; s < nslot; s++) begin
            bad_slot = 1'b0; bad_val = 1'b0;
            for (int j = 0; j < clks; j++) begin
                c = s * clks + j + 1;
                if (j == clks / 2) obs_bits[s] = txs[u];
                if (txs[u] !== expv[s]) begin bad_slot = 1'b1; bad_val = txs[u]; end
                if (rdy[u] !== 1'b0) rdy_bad++;
                if (fin[u] === 1'b1 && last_fin_cycle < 0) last_fin_cycle = c;
                if (c < f && fin[u] !== 1'b0) fin_early++;
                if (c == f) fin_last = fin[u];
                if (noise) begin
                    din[u] = 8'($urandom);
                    if (!hold) snd[u] = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
            total++;
            if (bad_slot) begin
                bad++; $display("FAIL u%0d byte %h slot %0d tx: got %b want %b", u, b, s, bad_val, expv[s]);
            end
        end
        if (!hold) snd[u] = 1'b0;
        total++;
        if (fin_last !== 1'b1 || fin_early != 0) begin
            bad++; $display("FAIL u%0d finished_send: got last=%b early=%0d want last=1 early=0", u, fin_last, fin_early);
        end
        total++;
        if (rdy_bad != 0) begin
            bad++; $display("FAIL u%0d ready in frame: got %0d high cycles want 0", u, rdy_bad);
        end
        total++;
        if (rdy[u] !== 1'b1 || txs[u] !== 1'b1 || fin[u] !== 1'b0) begin
            bad++; $display("FAIL u%0d idle after frame: got ready=%b tx=%b fin=%b want 1 1 0", u, rdy[u], txs[u], fin[u]);
        end
    endtask

    task automatic test_reset();
        rst = '1;
        snd = '0;
        for (int i = 0; i < 5; i++) din[i] = 8'h00;
        repeat (3) begin
            @(negedge clk);
            for (int u = 0; u < 5; u++) begin
                total++;
                if (txs[u] !== 1'b1 || rdy[u] !== 1'b1 || fin[u] !== 1'b0) begin
                    bad++; $display("FAIL reset u%0d: got tx=%b ready=%b fin=%b want 1 1 0", u, txs[u], rdy[u], fin[u]);
                end
            end
        end
        snd = '1;
        @(negedge clk);
        rst = '0;
        snd = '0;
        @(negedge clk);
        for (int u = 0; u < 5; u++) begin
            total++;
            if (txs[u] !== 1'b1 || rdy[u] !== 1'b1) begin
                bad++; $display("FAIL send during reset u%0d: got tx=%b ready=%b want 1 1", u, txs[u], rdy[u]);
            end
        end
    endtask

    task automatic test_single_a5();
        do_frame(0, 8'hA5, 1'b0, 1'b0);
        total++;
        if (last_fin_cycle != 5200) begin
            bad++; $display("FAIL a5 finish cycle: got %0d want 5200", last_fin_cycle);
        end
    endtask

    task automatic test_back_to_back();
        do_frame(0, 8'h11, 1'b1, 1'b1);
        do_frame(0, 8'h22, 1'b0, 1'b1);
        @(negedge clk);
        total++;
        if (txs[0] !== 1'b1 || rdy[0] !== 1'b1) begin
            bad++; $display("FAIL b2b no queued frame: got tx=%b ready=%b want 1 1", txs[0], rdy[0]);
        end
    endtask

    task automatic test_reset_mid_data();
        din[0] = 8'h00;
        snd[0] = 1'b1;
        @(negedge clk);
        snd[0] = 1'b0;
        repeat (5 * 520 + 259) @(negedge clk);
        total++;
        if (txs[0] !== 1'b0) begin
            bad++; $display("FAIL mid data bit4: got tx=%b want 0", txs[0]);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        total++;
        if (txs[0] !== 1'b1 || rdy[0] !== 1'b1 || fin[0] !== 1'b0) begin
            bad++; $display("FAIL abort: got tx=%b ready=%b fin=%b want 1 1 0", txs[0], rdy[0], fin[0]);
        end
        rst[0] = 1'b0;
        do_frame(0, 8'h5A, 1'b0, 1'b0);
    endtask

    task automatic test_parity_stop();
        do_frame(1, 8'h07, 1'b0, 1'b0);
        total++;
        if (obs_bits[9] !== 1'b1 || last_fin_cycle != 6240) begin
            bad++; $display("FAIL even parity: got bit=%b fin=%0d want 1 6240", obs_bits[9], last_fin_cycle);
        end
        do_frame(2, 8'h07, 1'b0, 1'b0);
        total++;
        if (obs_bits[9] !== 1'b0 || last_fin_cycle != 6240) begin
            bad++; $display("FAIL odd parity: got bit=%b fin=%0d want 0 6240", obs_bits[9], last_fin_cycle);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit hold, noise;
        for (int u = 3; u < 5; u++) begin
            for (int i = 0; i < 13; i++) begin
                b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h3C : 8'($urandom);
                hold  = (i < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
                noise = 1'($urandom_range(0, 1));
                do_frame(u, b, hold, noise);
                if (!hold) begin
                    @(negedge clk);
                    total++;
                    if (txs[u] !== 1'b1 || rdy[u] !== 1'b1) begin
                        bad++; $display("FAIL u%0d idle gap: got tx=%b ready=%b want 1 1", u, txs[u], rdy[u]);
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        obs_bits = '0;
        u_clks = '{5_000_000 / 9600, 5_000_000 / 9600, 5_000_000 / 9600, 40_000 / 9600, 29_000 / 9600};
        u_par  = '{0, 2, 1, 1, 0};
        u_stop = '{1, 2, 2, 1, 2};
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_reset_mid_data();
        test_parity_stop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transmit.md
Name: uart_transmit

Overview:
Serialises one byte per request onto a UART TX line: start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits. It is the transmit counterpart of uart_receive and sits upstream of it on the serial link. In loopback, tx is wired straight to uart_receive's rx. It shares the same clock and baud parameters, so both ends agree on bit timing.

Parameters:
CLK_HZ, 5_000_000, system clock frequency in Hz.
BAUD, 9600, line rate in bits/s.
CLKS_PER_BIT = CLK_HZ/BAUD with integer truncation; 520 at defaults. This is a derived localparam, not overridable.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
dataIn  in  8  byte to send; sampled only on the accept edge.
send  in  1  request, valid-style.
ready  out  1  high when idle and able to accept a request.
tx  out  1  serial line; idles high.
finished_send  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, sampled on the rising edge of clock.
  - Reset values: tx = 1, ready = 1, finished_send = 0, state = IDLE, bit counter = 0, baud counter = 0.
  - Reset has priority over every other event, including send on the same edge.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1, ready = 1. Accept occurs on an edge where send && ready. On accept, latch dataIn into a shift register, clear the baud counter, go to START.
  - START: tx = 0 for exactly CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shreg[0]. Shift right after every CLKS_PER_BIT cycles. After 8 bits, go to PARITY if PARITY != 0, else STOP.
  - PARITY: tx = ^byte (even parity) or ~^byte (odd parity), held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles. In the final cycle of the last stop bit, finished_send = 1 for that one cycle. Go to IDLE at that edge.
- ready is 0 in every state except IDLE.
- Latency and timing (accept edge = k):
  - tx falls in cycle k+1.
  - Frame length F = (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles.
  - finished_send is high in cycle k+F. ready returns high in cycle k+F+1.
- Back-to-back frames: send held high is re-accepted in the first IDLE cycle, giving exactly one extra idle-high cycle between frames.
- Ignored inputs:
  - send while ready = 0 is ignored, not queued.
  - dataIn changes after the accept edge do not affect the frame in flight.
- Baud counter: width clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps. Bit advance occurs on the wrap. No drift accumulates across a frame.
- Reset mid-frame: the frame is aborted; tx = 1 and ready = 1 from the cycle after reset is sampled. No finished_send pulse is produced.
- Elaboration checks: CLKS_PER_BIT >= 2, PARITY in {0,1,2}, STOP_BITS in {1,2}; anything else is a fatal error.

Test Plan:
- Reset values: hold reset 3 cycles -> tx = 1, ready = 1, finished_send = 0 throughout. Then send = 1 with reset = 1 -> no frame starts.
- Single byte 0xA5, defaults: pulse send for 1 cycle at edge k ->
  - tx = 0 for cycles k+1..k+520;
  - then bits 1,0,1,0,0,1,0,1, 520 cycles each;
  - then stop high;
  - finished_send high only at k+5200; ready high again at k+5201.
- Loopback 0x00, 0xFF, 0x3C into uart_receive #(5_000_000, 9600): each byte appears on dataOut with a finished_read pulse. No framing errors.
- Parity and stop: PARITY = 2 (even), STOP_BITS = 2, byte 0x07 ->
  - parity bit = 1;
  - frame length 12*520 = 6240 cycles;
  - finished_send at k+6240.
  - Repeat with PARITY = 1 (odd): parity bit = 0.
- Back-to-back with ignored stimulus: hold send = 1 with dataIn = 0x11, then 0x22. Toggle dataIn and pulse send mid-frame ->
  - two clean frames, 0x11 then 0x22;
  - exactly one idle-high cycle between them;
  - mid-frame changes and requests ignored.
- Reset mid-DATA: assert reset in bit 4 of a frame -> tx = 1 the next cycle, no finished_send pulse. A new send is accepted 1 cycle after reset deasserts.
